// File: rtl/reg_seq_pkg.sv
// reg_seq_pkg: shared op/state encodings and default widths for reg_file_sequencer.
package reg_seq_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_AND, OP_OR} op_t;
    typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WRITE, S_DONE, S_INIT} state_t;
endpackage

// File: rtl/seq_alu.sv
// seq_alu: combinational ADD/SUB/AND/OR with carry (borrow on SUB) and zero flags.
module seq_alu
    import reg_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [1:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);
    logic [DATA_W:0] sum, diff;
    assign sum  = {1'b0, A} + {1'b0, B};
    // The extra bit of a zero-extended difference is set exactly when A < B.
    assign diff = {1'b0, A} - {1'b0, B};
    always_comb begin
        result = op == OP_ADD ? sum[DATA_W-1:0] :
                 op == OP_SUB ? diff[DATA_W-1:0] :
                 op == OP_AND ? A & B : A | B;
        carry  = op == OP_ADD ? sum[DATA_W] : op == OP_SUB ? diff[DATA_W] : 1'b0;
        zero   = result == '0;
    end
endmodule

// File: rtl/reg_file_sequencer.sv
// reg_file_sequencer: go-triggered read/ALU/write-back controller for the 8x16 reg_file.
// Define REG_SEQ_INIT_SWEEP_EN to zero every register after reset before accepting work.
module reg_file_sequencer
    import reg_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] src_a,
    input  logic [ADDR_W-1:0] src_b,
    input  logic [ADDR_W-1:0] dst,
    input  logic [DATA_W-1:0] R_in,
    input  logic [DATA_W-1:0] S_in,
    output logic [ADDR_W-1:0] R_adr,
    output logic [ADDR_W-1:0] S_adr,
    output logic [ADDR_W-1:0] W_adr,
    output logic [DATA_W-1:0] W,
    output logic              we,
    output logic              busy,
    output logic              done,
    output logic              carry,
    output logic              zero
);
`ifdef REG_SEQ_INIT_SWEEP_EN
    localparam state_t RST_STATE = S_INIT;
`else
    localparam state_t RST_STATE = S_IDLE;
`endif
    state_t            state, next;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] a_q, b_q, res;
    logic              alu_c, alu_z;

    seq_alu #(.DATA_W(DATA_W)) u_alu (
        .A(a_q), .B(b_q), .op(op_q), .result(res), .carry(alu_c), .zero(alu_z)
    );

    always_ff @(posedge clk)
        state <= reset ? RST_STATE : next;

    always_comb begin
        next = state == S_INIT  ? (W_adr == '1 ? S_IDLE : S_INIT) :
               state == S_IDLE  ? (go ? S_READ : S_IDLE) :
               state == S_READ  ? S_EXEC :
               state == S_EXEC  ? S_WRITE :
               state == S_WRITE ? S_DONE : S_IDLE;
    end

    // Strobes decode straight from the state register, so they stay glitch-free and input-independent.
    assign busy = state != S_IDLE;
    assign we   = state == S_WRITE || state == S_INIT;
    assign done = state == S_DONE;

    // The read/write address registers double as the latched operands and, during INIT, the sweep counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            R_adr <= '0;
            S_adr <= '0;
            W_adr <= '0;
            W     <= '0;
            carry <= 1'b0;
            zero  <= 1'b0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            if (state == S_INIT)
                W_adr <= W_adr + 1'b1;
            if (state == S_IDLE && go) begin
                op_q  <= op;
                R_adr <= src_a;
                S_adr <= src_b;
                W_adr <= dst;
            end
            if (state == S_READ) begin
                a_q <= R_in;
                b_q <= S_in;
            end
            if (state == S_EXEC) begin
                W     <= res;
                carry <= alu_c;
                zero  <= alu_z;
            end
        end
    end
endmodule

// File: tb/tb_reg_file_sequencer.sv
// tb_reg_file_sequencer: directed tests against a timeline model of the sequencer plus a bench-side reg_file.
module tb_reg_file_sequencer;
    import reg_seq_pkg::*;
`ifdef REG_SEQ_INIT_SWEEP_EN
    localparam bit SWEEP = 1'b1;
`else
    localparam bit SWEEP = 1'b0;
`endif
    logic        clk = 0, reset = 1, go = 0;
    logic [1:0]  op = 0;
    logic [2:0]  src_a = 0, src_b = 0, dst = 0;
    logic [15:0] R_in, S_in, W;
    logic [2:0]  R_adr, S_adr, W_adr;
    logic        we, busy, done, carry, zero;
    logic [15:0] rf [8];
    logic        pl_en = 0;
    logic [2:0]  pl_adr = 0;
    logic [15:0] pl_dat = 0;
    int          n_chk = 0, n_fail = 0, we_cnt = 0, done_cnt = 0;

    always #5 clk = ~clk;

    reg_file_sequencer dut (
        .clk(clk), .reset(reset), .go(go), .op(op), .src_a(src_a), .src_b(src_b), .dst(dst),
        .R_in(R_in), .S_in(S_in), .R_adr(R_adr), .S_adr(S_adr), .W_adr(W_adr), .W(W),
        .we(we), .busy(busy), .done(done), .carry(carry), .zero(zero)
    );

    // Stand-in for reg_file: combinational reads, clocked write, plus a preload port for the bench.
    assign R_in = rf[R_adr];
    assign S_in = rf[S_adr];
    always @(posedge clk)
        if (we) rf[W_adr] <= W;
        else if (pl_en) rf[pl_adr] <= pl_dat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: ph counts cycles since an accepted go (0 = idle), ini counts remaining sweep writes.
    int          ph = 0, ini = 0, mx, my;
    bit          armed = 0, ec = 0, ez = 0, m_c, w_exp;
    logic [15:0] mdl [8];
    logic [15:0] m_res;
    logic [2:0]  m_d;
    always @(posedge clk) begin
        if (reset) begin
            ph = 0; ec = 0; ez = 0; armed = 1;
            ini = SWEEP ? 8 : 0;
        end else if (ini > 0) begin
            mdl[8-ini] = 16'h0;
            ini--;
        end else if (ph == 0) begin
            if (pl_en) mdl[pl_adr] = pl_dat;
            if (go) begin
                mx = int'(mdl[src_a]);
                my = int'(mdl[src_b]);
                m_d = dst;
                case (op)
                    2'd0: begin m_res = 16'((mx + my) % 65536); m_c = (mx + my) > 65535; end
                    2'd1: begin m_res = 16'((mx - my + 65536) % 65536); m_c = mx < my; end
                    2'd2: begin m_res = 16'(mx & my); m_c = 0; end
                    default: begin m_res = 16'(mx | my); m_c = 0; end
                endcase
                ph = 1;
            end
        end else begin
            if (ph == 2) begin ec = m_c; ez = m_res == 16'h0; end
            if (ph == 3) mdl[m_d] = m_res;
            ph = (ph + 1) % 5;
        end
    end

    always @(negedge clk) if (armed) begin
        w_exp = ini > 0 || ph == 3;
        chk("busy", busy, ini > 0 || ph != 0);
        chk("we", we, w_exp);
        chk("done", done, ph == 4);
        chk("carry", carry, ec);
        chk("zero", zero, ez);
        if (w_exp) begin
            chk("W_adr", W_adr, ini > 0 ? 3'(8 - ini) : m_d);
            chk("W", W, ini > 0 ? 16'h0 : m_res);
        end
        if (we) we_cnt++;
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        pl_en = 1; pl_adr = a; pl_dat = d;
        tick();
        pl_en = 0;
    endtask

    task automatic start(input logic [1:0] o, input logic [2:0] a, input logic [2:0] b, input logic [2:0] d);
        go = 1; op = o; src_a = a; src_b = b; dst = d;
        tick();
        go = 0; op = ~o; src_a = ~a; src_b = ~b; dst = ~d;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 30) begin
            tick();
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    int w0, d0;
    initial begin
        tick();
        tick();
        reset = 0;
        chk("rst_we", we, 0);
        chk("rst_done", done, 0);
        chk("rst_carry", carry, 0);
        chk("rst_zero", zero, 0);
        chk("rst_W", W, 16'h0);
        chk("rst_adr", {R_adr, S_adr, W_adr}, 9'h0);
        chk("rst_busy", busy, SWEEP);
        wait_idle();
        chk("sweep_we_count", we_cnt, SWEEP ? 8 : 0);
        for (int i = 0; i < 8; i++) preload(3'(i), 16'h1111 * 16'(i));
        preload(3'd1, 16'hFFFF); preload(3'd2, 16'h0001);
        preload(3'd4, 16'h0003); preload(3'd5, 16'h0005);
        preload(3'd6, 16'h1234); preload(3'd0, 16'h00F0);
        preload(3'd7, 16'h0F0F);

        start(OP_ADD, 3'd1, 3'd2, 3'd3);
        chk("add_busy_c1", busy, 1);
        tick();
        chk("add_we_c2", we, 0);
        tick();
        chk("add_we_c3", we, 1);
        chk("add_wadr", W_adr, 3'd3);
        chk("add_w", W, 16'h0000);
        tick();
        chk("add_done_c4", done, 1);
        chk("add_carry", carry, 1);
        chk("add_zero", zero, 1);
        tick();
        chk("add_idle_c5", busy, 0);
        chk("add_reg3", rf[3], 16'h0000);

        start(OP_SUB, 3'd4, 3'd5, 3'd4);
        wait_idle();
        chk("sub_reg4", rf[4], 16'hFFFE);
        chk("sub_carry", carry, 1);
        chk("sub_zero", zero, 0);

        start(OP_AND, 3'd0, 3'd7, 3'd2);
        wait_idle();
        chk("and_reg2", rf[2], 16'h0000);
        chk("and_zero", zero, 1);
        chk("and_carry", carry, 0);

        start(OP_OR, 3'd0, 3'd7, 3'd5);
        wait_idle();
        chk("or_reg5", rf[5], 16'h0FFF);
        chk("or_zero", zero, 0);

        start(OP_SUB, 3'd7, 3'd7, 3'd1);
        wait_idle();
        chk("same_reg1", rf[1], 16'h0000);
        chk("same_zero", zero, 1);

        w0 = we_cnt; d0 = done_cnt;
        start(OP_ADD, 3'd0, 3'd7, 3'd2);
        go = 1; op = OP_OR; src_a = 3'd6; src_b = 3'd6; dst = 3'd6;
        tick();
        go = 0;
        tick();
        go = 1;
        tick();
        go = 0;
        tick();
        start(OP_OR, 3'd0, 3'd0, 3'd3);
        wait_idle();
        chk("ign_we_count", we_cnt - w0, 2);
        chk("ign_done_count", done_cnt - d0, 2);
        chk("ign_reg2", rf[2], 16'h0FFF);
        chk("ign_reg3", rf[3], 16'h00F0);
        chk("ign_reg6", rf[6], 16'h1234);

        w0 = we_cnt; d0 = done_cnt;
        start(OP_SUB, 3'd6, 3'd0, 3'd6);
        tick();
        reset = 1;
        tick();
        reset = 0;
        chk("rst_mid_busy", busy, SWEEP);
        chk("rst_mid_carry", carry, 0);
        wait_idle();
        chk("rst_mid_reg6", rf[6], SWEEP ? 16'h0000 : 16'h1234);
        chk("rst_mid_we_count", we_cnt - w0, SWEEP ? 8 : 0);
        chk("rst_mid_done_count", done_cnt - d0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
